// File: rtl/apb_matmul_slave.sv
// APB completer for the matmul engine: control, operand rows, status and
// scratchpad read windows with a fixed-latency wait path.
module apb_matmul_slave #(
    parameter int BW          = 64,
    parameter int DW          = 16,
    parameter int ADDR_W      = 32,
    parameter int SP_NTARGETS = 4,
    parameter int MAX_DIM     = BW / DW,
    parameter int SP_RD_LAT   = 2,
    localparam int SUB_ADDRESS_BITS = (MAX_DIM > 2) ? 4 : 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        psel_i,
    input  logic                        penable_i,
    input  logic                        pwrite_i,
    input  logic [ADDR_W-1:0]           paddr_i,
    input  logic [BW-1:0]               pwdata_i,
    input  logic [MAX_DIM-1:0]          pstrb_i,
    output logic [BW-1:0]               prdata_o,
    output logic                        pready_o,
    output logic                        pslverr_o,
    output logic [MAX_DIM*BW-1:0]       op_a_o,
    output logic [MAX_DIM*BW-1:0]       op_b_o,
    output logic [15:0]                 ctrl_o,
    output logic                        start_o,
    input  logic                        busy_i,
    input  logic                        done_i,
    output logic                        sp_rd_en_o,
    output logic [1:0]                  sp_sel_o,
    output logic [SUB_ADDRESS_BITS-1:0] sp_addr_o,
    input  logic [BW-1:0]               sp_rdata_i
);

    localparam int SAB = SUB_ADDRESS_BITS;
    localparam int RW  = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
    localparam int CW  = $clog2(SP_RD_LAT + 1);
    localparam logic [15:0] CTRL_MASK = 16'h3F3E;

    typedef enum logic [1:0] {IDLE, ACCESS, SP_WAIT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sp_rd_q, sp_rd_d;
    logic [BW-1:0] op_a_q [MAX_DIM];
    logic [BW-1:0] op_b_q [MAX_DIM];
    logic [15:0]   ctrl_q;
    logic          done_q;
    logic          start_q;

    logic [4:0]     off;
    logic [SAB-1:0] sub;
    logic [RW-1:0]  row;
    logic is_ctrl, is_a, is_b, is_st, is_sp, is_op, bad, row_ok;
    logic acc_err;
    logic wr_ctrl, wr_a, wr_b, w1c;
    logic unused_addr;

    assign off     = paddr_i[4:0];
    assign sub     = paddr_i[SAB+4:5];
    assign row     = sub[RW-1:0];
    assign is_ctrl = (off == 5'h00);
    assign is_a    = (off == 5'h04);
    assign is_b    = (off == 5'h08);
    assign is_st   = (off == 5'h0C);
    assign is_sp   = off[4] && (off[1:0] == 2'b00);
    assign is_op   = is_a || is_b;
    assign bad     = !(is_ctrl || is_op || is_st || is_sp);
    assign row_ok  = (sub < SAB'(MAX_DIM));

    assign unused_addr = ^paddr_i[ADDR_W-1:SAB+5];

    // SP reads that got a scratchpad request never reach this path;
    // an SP read here was refused for busy at setup.
    assign acc_err = bad
                  || (is_op && !row_ok)
                  || (!pwrite_i && is_sp)
                  || (pwrite_i && (is_sp
                      || (is_st && (|pwdata_i[BW-1:1]))
                      || ((is_ctrl || is_op) && busy_i)));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sp_rd_d    = sp_rd_q;
        pready_o   = 1'b0;
        pslverr_o  = 1'b0;
        prdata_o   = '0;
        sp_rd_en_o = 1'b0;
        wr_ctrl    = 1'b0;
        wr_a       = 1'b0;
        wr_b       = 1'b0;
        w1c        = 1'b0;
        case (state_q)
            IDLE: begin
                if (psel_i && !penable_i) begin
                    state_d    = ACCESS;
                    cnt_d      = CW'(1);
                    sp_rd_en_o = !pwrite_i && is_sp && !busy_i;
                    sp_rd_d    = sp_rd_en_o;
                end
            end
            ACCESS, SP_WAIT: begin
                if (sp_rd_q) begin
                    if (cnt_q == CW'(SP_RD_LAT)) begin
                        pready_o = 1'b1;
                        prdata_o = sp_rdata_i;
                        sp_rd_d  = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        state_d = SP_WAIT;
                    end
                end else begin
                    pready_o  = 1'b1;
                    pslverr_o = acc_err;
                    state_d   = IDLE;
                    if (!acc_err && pwrite_i) begin
                        wr_ctrl = is_ctrl;
                        wr_a    = is_a;
                        wr_b    = is_b;
                        w1c     = is_st && pwdata_i[0];
                    end else if (!acc_err) begin
                        unique case (1'b1)
                            is_ctrl: prdata_o = {{(BW-16){1'b0}}, ctrl_q};
                            is_a:    prdata_o = op_a_q[row];
                            is_b:    prdata_o = op_b_q[row];
                            is_st:   prdata_o = {{(BW-2){1'b0}}, busy_i, done_q};
                            default: prdata_o = '0;
                        endcase
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst_i) begin
            pready_o   = 1'b0;
            pslverr_o  = 1'b0;
            prdata_o   = '0;
            sp_rd_en_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sp_rd_q <= 1'b0;
            ctrl_q  <= '0;
            done_q  <= 1'b0;
            start_q <= 1'b0;
            for (int r = 0; r < MAX_DIM; r++) begin
                op_a_q[r] <= '0;
                op_b_q[r] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sp_rd_q <= sp_rd_d;
            start_q <= wr_ctrl && pwdata_i[0];
            done_q  <= done_i || (done_q && !w1c);
            if (wr_ctrl)
                ctrl_q <= pwdata_i[15:0] & CTRL_MASK;
            for (int e = 0; e < MAX_DIM; e++) begin
                if (wr_a && pstrb_i[e])
                    op_a_q[row][e*DW +: DW] <= pwdata_i[e*DW +: DW];
                if (wr_b && pstrb_i[e])
                    op_b_q[row][e*DW +: DW] <= pwdata_i[e*DW +: DW];
            end
        end
    end

    for (genvar r = 0; r < MAX_DIM; r++) begin : g_rows
        assign op_a_o[r*BW +: BW] = op_a_q[r];
        assign op_b_o[r*BW +: BW] = op_b_q[r];
    end

    assign ctrl_o    = ctrl_q;
    assign start_o   = start_q;
    assign sp_sel_o  = sp_rd_en_o ? paddr_i[3:2] : 2'b00;
    assign sp_addr_o = sp_rd_en_o ? sub : '0;

endmodule
